// File: rtl/rtc_edit_pkg.sv
// ---------------------------------------------------------------------------
// rtc_edit_pkg
// Shared definitions for the RTC date/time edit front-end:
//   - field code width and the FIELD_* codes driven on en_count
//   - default number of editable fields
//   - FSM state encoding of the edit controller
//   - field_step(): wrap-around navigation helper
// ---------------------------------------------------------------------------
package rtc_edit_pkg;

    localparam int FIELD_W        = 4;
    localparam int NUM_FIELDS_DEF = 6;

    localparam logic [FIELD_W-1:0] FIELD_NONE  = 4'd0;
    localparam logic [FIELD_W-1:0] FIELD_HOUR  = 4'd1;
    localparam logic [FIELD_W-1:0] FIELD_MIN   = 4'd2;
    localparam logic [FIELD_W-1:0] FIELD_SEC   = 4'd3;
    localparam logic [FIELD_W-1:0] FIELD_YEAR  = 4'd4;
    localparam logic [FIELD_W-1:0] FIELD_MONTH = 4'd5;
    localparam logic [FIELD_W-1:0] FIELD_DAY   = 4'd6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } edit_state_t;

    // Move one field forward or backward, wrapping between 1 and last.
    function automatic logic [FIELD_W-1:0] field_step(
        input logic [FIELD_W-1:0] cur,
        input logic               fwd,
        input logic [FIELD_W-1:0] last
    );
        if (fwd) begin
            return (cur >= last) ? FIELD_HOUR : cur + 4'd1;
        end
        return (cur <= FIELD_HOUR) ? last : cur - 4'd1;
    endfunction

endpackage

// File: rtl/rtc_step_repeat.sv
// ---------------------------------------------------------------------------
// rtc_step_repeat
// One step direction (up or down) of the edit path. Turns a registered
// button level into single-cycle step pulses, with optional hold-to-repeat.
//
// Build option: AUTO_REPEAT_EN
//   defined   - while the button stays held, a repeat pulse follows the
//               initial one after HOLD_TICKS ticks, then every REPEAT_TICKS
//               ticks (one tick = TICK_DIV clk cycles).
//   undefined - exactly one pulse per press; no prescaler/repeat counter.
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   btn_i       registered button level of this direction
//   block_i     registered level of the opposite button (suppresses stepping)
//   enable_i    high while the controller is in EDIT
//   pulse_o     registered one-cycle step pulse
// ---------------------------------------------------------------------------
module rtc_step_repeat #(
    parameter int TICK_DIV     = 1000000,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    input  logic block_i,
    input  logic enable_i,
    output logic pulse_o
);

    logic btn_prev_q;
    logic rise;
    logic start;
    logic pulse_d;
    logic pulse_q;

    // The previous copy tracks the button in every state, so a button held
    // across EDIT entry shows no rising edge until it is pressed again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev_q <= 1'b0;
        end else begin
            btn_prev_q <= btn_i;
        end
    end

    assign rise  = btn_i & ~btn_prev_q;
    assign start = rise & ~block_i & enable_i;

`ifdef AUTO_REPEAT_EN
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_T  = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int REP_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_TICKS - 1);
    localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEAT_TICKS - 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             active_q, active_d;
    logic             held_q, held_d;      // initial hold period has elapsed
    logic             keep;
    logic             tick;
    logic             fire;

    // Repeat continues only while the press that started it is still valid.
    assign keep = active_q & btn_i & ~block_i & enable_i;
    assign tick = keep & (presc_q == PRE_LAST);
    assign fire = tick & (rep_q == (held_q ? REP_LAST : HOLD_LAST));

    always_comb begin
        presc_d  = presc_q;
        rep_d    = rep_q;
        active_d = active_q;
        held_d   = held_q;
        if (start) begin
            presc_d  = '0;
            rep_d    = '0;
            active_d = 1'b1;
            held_d   = 1'b0;
        end else if (!keep) begin
            presc_d  = '0;
            rep_d    = '0;
            active_d = 1'b0;
            held_d   = 1'b0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (fire) begin
                rep_d  = '0;
                held_d = 1'b1;
            end else if (tick) begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            rep_q    <= '0;
            active_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            rep_q    <= rep_d;
            active_q <= active_d;
            held_q   <= held_d;
        end
    end

    assign pulse_d = start | fire;
`else
    logic [31:0] unused_params;

    assign unused_params = TICK_DIV ^ HOLD_TICKS ^ REPEAT_TICKS;
    assign pulse_d       = start;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/rtc_edit_ctrl.sv
// ---------------------------------------------------------------------------
// rtc_edit_ctrl
// Front-end sequencer for the RTC date/time edit path. Selects the field
// being edited (en_count), issues single-cycle enUP/enDOWN step strobes in
// the clk domain, and on leaving edit mode runs a wr_req/wr_ack handshake so
// the RTC write sequencer can commit the edited values.
//
// Build option: AUTO_REPEAT_EN enables hold-to-repeat on the step buttons
// (see rtc_step_repeat). Without it each press gives exactly one strobe.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   edit_mode       level, requests edit mode
//   btn_left/right  debounced levels, previous/next field
//   btn_up/down     debounced levels, increment/decrement selected field
//   wr_ack          commit acknowledge (only honoured in COMMIT)
//   en_count        selected field code, 0 when not editing
//   enUP, enDOWN    one-cycle step strobes
//   wr_req          commit request, held until acknowledged
//   busy            high in EDIT or COMMIT
// ---------------------------------------------------------------------------
import rtc_edit_pkg::*;

module rtc_edit_ctrl #(
    parameter int TICK_DIV     = 1000000,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 25,
    parameter int NUM_FIELDS   = NUM_FIELDS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       edit_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       wr_ack,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       wr_req,
    output logic       busy
);

    localparam logic [FIELD_W-1:0] FIELD_LAST = FIELD_W'(NUM_FIELDS);

    logic edit_q, left_q, right_q, up_q, down_q;
    logic left_prev_q, right_prev_q;
    logic left_rise, right_rise;
    logic in_edit;

    edit_state_t        state_q, state_d;
    logic [FIELD_W-1:0] field_q, field_d;

    // Single input register for all level inputs, plus the previous copy of
    // the navigation buttons for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edit_q       <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            left_prev_q  <= 1'b0;
            right_prev_q <= 1'b0;
        end else begin
            edit_q       <= edit_mode;
            left_q       <= btn_left;
            right_q      <= btn_right;
            up_q         <= btn_up;
            down_q       <= btn_down;
            left_prev_q  <= left_q;
            right_prev_q <= right_q;
        end
    end

    assign left_rise  = left_q & ~left_prev_q;
    assign right_rise = right_q & ~right_prev_q;
    assign in_edit    = (state_q == EDIT);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            field_q <= FIELD_NONE;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        field_d = field_q;
        unique case (state_q)
            IDLE: begin
                if (edit_q) begin
                    state_d = EDIT;
                    field_d = FIELD_HOUR;
                end
            end
            EDIT: begin
                if (!edit_q) begin
                    state_d = COMMIT;
                end else if (right_rise && !left_rise) begin
                    field_d = field_step(field_q, 1'b1, FIELD_LAST);
                end else if (left_rise && !right_rise) begin
                    field_d = field_step(field_q, 1'b0, FIELD_LAST);
                end
            end
            COMMIT: begin
                if (wr_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        en_count = in_edit ? field_q : FIELD_NONE;
        wr_req   = (state_q == COMMIT);
        busy     = (state_q != IDLE);
    end

    // Each direction is blocked by the other button, so the strobes can
    // never coincide and both held means no stepping or repeat at all.
    rtc_step_repeat #(
        .TICK_DIV     (TICK_DIV),
        .HOLD_TICKS   (HOLD_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) u_step_up (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (up_q),
        .block_i  (down_q),
        .enable_i (in_edit),
        .pulse_o  (enUP)
    );

    rtc_step_repeat #(
        .TICK_DIV     (TICK_DIV),
        .HOLD_TICKS   (HOLD_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) u_step_down (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (down_q),
        .block_i  (up_q),
        .enable_i (in_edit),
        .pulse_o  (enDOWN)
    );

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
module tb_rtc_edit_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       edit_mode, btn_left, btn_right, btn_up, btn_down, wr_ack;
    logic [3:0] en_count;
    logic       enUP, enDOWN, wr_req, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int up_cnt = 0;
    int dn_cnt = 0;

    typedef struct {
        int   cyc;
        logic up;
        int   field;
    } exp_t;

    exp_t sb[$];

    rtc_edit_ctrl #(
        .TICK_DIV     (4),
        .HOLD_TICKS   (3),
        .REPEAT_TICKS (2),
        .NUM_FIELDS   (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .edit_mode (edit_mode),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .wr_ack    (wr_ack),
        .en_count  (en_count),
        .enUP      (enUP),
        .enDOWN    (enDOWN),
        .wr_req    (wr_req),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (enUP === 1'b1 || enDOWN === 1'b1) begin
            if (enUP === 1'b1) up_cnt++;
            if (enDOWN === 1'b1) dn_cnt++;
            chk("strobe_exclusive", 32'(enUP & enDOWN), 0);
            if (sb.size() == 0) begin
                chk("strobe_unexpected", {30'd0, enUP, enDOWN}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobe_dir", 32'(enUP), 32'(e.up));
                chk("strobe_field", 32'(en_count), e.field);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic nav(input bit right, input int exp_field);
        if (right) btn_right = 1'b1;
        else btn_left = 1'b1;
        tick();
        btn_right = 1'b0;
        btn_left  = 1'b0;
        tick();
        chk(right ? "nav_right" : "nav_left", 32'(en_count), exp_field);
    endtask

    task automatic press_step(input bit up, input int field);
        exp_t e;
        e.cyc = cyc + 2;
        e.up = up;
        e.field = field;
        sb.push_back(e);
        if (up) btn_up = 1'b1;
        else btn_down = 1'b1;
        tick();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, d0, t0;
        exp_t e;
        reset = 1'b1;
        edit_mode = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; wr_ack = 1'b0;
        tick(2);
        chk("rst_en_count", 32'(en_count), 0);
        chk("rst_strobes", {30'd0, enUP, enDOWN}, 0);
        chk("rst_wr_req", 32'(wr_req), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick(2);

        // Enter edit mode: field 1 two cycles after edit_mode rises
        edit_mode = 1'b1;
        tick();
        chk("entry_not_yet", 32'(busy), 0);
        tick();
        chk("entry_en_count", 32'(en_count), 1);
        chk("entry_busy", 32'(busy), 1);
        chk("entry_no_strobe", {30'd0, enUP, enDOWN}, 0);

        // Navigation with wrap in both directions
        nav(1, 2); nav(1, 3); nav(1, 4); nav(1, 5);
        nav(1, 6); nav(1, 1); nav(1, 2);
        nav(0, 1);
        nav(0, 6);
        nav(1, 1);
        nav(1, 2); nav(1, 3); nav(1, 4);

        // Both navigation buttons together: no change
        btn_left = 1'b1; btn_right = 1'b1;
        tick();
        btn_left = 1'b0; btn_right = 1'b0;
        tick(2);
        chk("nav_both", 32'(en_count), 4);

        // Single up press on YEAR, then a single down press
        u0 = up_cnt; d0 = dn_cnt;
        press_step(1, 4);
        chk("up_once_cnt", up_cnt - u0, 1);
        chk("up_once_no_down", dn_cnt - d0, 0);
        press_step(0, 4);
        chk("down_once_cnt", dn_cnt - d0, 1);

        // Up and down rise together: no strobes while both held
        u0 = up_cnt; d0 = dn_cnt;
        btn_up = 1'b1; btn_down = 1'b1;
        tick(12);
        btn_up = 1'b0; btn_down = 1'b0;
        tick(3);
        chk("both_no_up", up_cnt - u0, 0);
        chk("both_no_down", dn_cnt - d0, 0);

        // Held up button
        u0 = up_cnt;
        t0 = cyc;
`ifdef AUTO_REPEAT_EN
        e.up = 1'b1; e.field = 4;
        e.cyc = t0 + 2;  sb.push_back(e);
        e.cyc = t0 + 14; sb.push_back(e);
        e.cyc = t0 + 22; sb.push_back(e);
        btn_up = 1'b1;
        tick(25);
        btn_up = 1'b0;
        tick(10);
        chk("repeat_cnt", up_cnt - u0, 3);
`else
        e.up = 1'b1; e.field = 4;
        e.cyc = t0 + 2; sb.push_back(e);
        btn_up = 1'b1;
        tick(100);
        btn_up = 1'b0;
        tick(3);
        chk("hold_single_cnt", up_cnt - u0, 1);
`endif

        // wr_ack outside COMMIT is ignored
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        tick();
        chk("ack_ignored_busy", 32'(busy), 1);
        chk("ack_ignored_field", 32'(en_count), 4);

        // Commit handshake with delayed acknowledge
        edit_mode = 1'b0;
        tick(2);
        chk("commit_en_count", 32'(en_count), 0);
        chk("commit_wr_req", 32'(wr_req), 1);
        chk("commit_busy", 32'(busy), 1);
        tick(5);
        chk("commit_wr_req_held", 32'(wr_req), 1);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk("ack_wr_req", 32'(wr_req), 0);
        chk("ack_busy", 32'(busy), 0);
        tick(2);
        chk("idle_stays", 32'(busy), 0);

        // Re-enter edit, leave, then reset in the middle of COMMIT
        edit_mode = 1'b1;
        tick(2);
        chk("reentry_field", 32'(en_count), 1);
        edit_mode = 1'b0;
        tick(2);
        chk("commit2_wr_req", 32'(wr_req), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_commit_wr_req", 32'(wr_req), 0);
        chk("rst_mid_commit_busy", 32'(busy), 0);
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("post_rst_wr_req", 32'(wr_req), 0);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
